// File: rtl/cs_arb_pkg.sv
// Shared types and helpers for the round-robin chip-select arbiter.
// Holds the FSM state encoding, requester count and the round-robin search.
package cs_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // First set request strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/decoder3to8.sv
// Active-low 3-to-8 decoder: exactly one output low, selected by d.
module decoder3to8 (
  input  logic [2:0] d,
  output logic [7:0] y
);

  assign y = ~(8'b1 << d);

endmodule

// File: rtl/cs_rr_arbiter.sv
// Round-robin arbiter sharing one active-low chip-select decoder among 8 requesters.
// A grant is held until done, request drop or MAX_HOLD, then a guard gap follows.
module cs_rr_arbiter
  import cs_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic                   done,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid,
  output logic                   timeout,
  output logic [N_REQ-1:0]       cs_n
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_grant_valid;
  logic               r_timeout;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_valid_nxt;
  logic               w_timeout_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;

  logic               w_hold_last;
  logic               w_gap_last;
  logic               w_holder_req;
  logic [N_REQ-1:0]   w_dec_n;

  assign w_hold_last  = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign w_gap_last   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign w_holder_req = req[r_grant_idx];

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_grant_idx;
    w_valid_nxt   = r_grant_valid;
    w_timeout_nxt = 1'b0;
    w_hold_nxt    = r_hold_cnt;
    w_gap_nxt     = r_gap_cnt;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_idx_nxt   = rr_pick(req, r_grant_idx);
          w_valid_nxt = 1'b1;
          w_hold_nxt  = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (done || !w_holder_req || w_hold_last) begin
          w_valid_nxt   = 1'b0;
          w_gap_nxt     = '0;
          w_state_nxt   = GAP;
          // Timeout only flags a revocation the holder did not ask for.
          w_timeout_nxt = w_hold_last && !done && w_holder_req;
        end else begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      GAP: begin
        if (w_gap_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_grant_idx   <= IDX_W'(N_REQ - 1);
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_hold_cnt    <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_idx   <= w_idx_nxt;
      r_grant_valid <= w_valid_nxt;
      r_timeout     <= w_timeout_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_gap_cnt     <= w_gap_nxt;
    end
  end

  decoder3to8 u_dec (
    .d (r_grant_idx),
    .y (w_dec_n)
  );

  // Decoded from registered state only, so selects never glitch.
  assign cs_n        = r_grant_valid ? w_dec_n : 8'hFF;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// Self-checking bench for cs_rr_arbiter: per-cycle expectations are queued as
// inputs are driven and compared one cycle later against the outputs.
module tb_cs_rr_arbiter;

  localparam int W = 13;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;
  logic [7:0] cs_n;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;
  int           n_cycle;
  string        phase;

  cs_rr_arbiter #(.MAX_HOLD(16), .GAP_CYCLES(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout),
    .cs_n        (cs_n)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed expectation {cs_n, grant_valid, grant_idx, timeout}
  function automatic logic [W-1:0] pk(input logic gv, input logic [2:0] idx, input logic to);
    logic [7:0] c;
    logic [7:0] one;
    one = 8'd1;
    c   = gv ? ~(one << idx) : 8'hFF;
    return {c, gv, idx, to};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, n_cycle, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the state expected after the edge, compare.
  task automatic drive_cycle(input logic r, input logic [7:0] q, input logic d,
                             input logic [W-1:0] e);
    logic [W-1:0] x;
    rst  = r;
    req  = q;
    done = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_cycle++;
    x = exp_q.pop_front();
    check({phase, " cs_n"},        cs_n,                x[12:5]);
    check({phase, " grant_valid"}, {7'd0, grant_valid}, {7'd0, x[4]});
    check({phase, " grant_idx"},   {5'd0, grant_idx},   {5'd0, x[3:1]});
    check({phase, " timeout"},     {7'd0, timeout},     {7'd0, x[0]});
  endtask

  initial begin
    int idle_n;
    n_checks = 0;
    n_errors = 0;
    n_cycle  = 0;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    phase = "reset";
    drive_cycle(1'b1, 8'hFF, 1'b0, pk(1'b0, 3'd7, 1'b0));
    drive_cycle(1'b1, 8'hFF, 1'b1, pk(1'b0, 3'd7, 1'b0));

    phase = "single";
    drive_cycle(1'b0, 8'h04, 1'b0, pk(1'b1, 3'd2, 1'b0));
    drive_cycle(1'b0, 8'h04, 1'b0, pk(1'b1, 3'd2, 1'b0));
    drive_cycle(1'b0, 8'h04, 1'b0, pk(1'b1, 3'd2, 1'b0));
    drive_cycle(1'b0, 8'h04, 1'b1, pk(1'b0, 3'd2, 1'b0));
    drive_cycle(1'b0, 8'h00, 1'b0, pk(1'b0, 3'd2, 1'b0));
    idle_n = $urandom_range(1, 4);
    for (int i = 0; i < idle_n; i++)
      drive_cycle(1'b0, 8'h00, 1'b0, pk(1'b0, 3'd2, 1'b0));

    phase = "rotate";
    drive_cycle(1'b1, 8'h00, 1'b0, pk(1'b0, 3'd7, 1'b0));
    for (int k = 0; k < 9; k++) begin
      drive_cycle(1'b0, 8'hFF, 1'b0, pk(1'b1, 3'(k % 8), 1'b0));
      drive_cycle(1'b0, 8'hFF, 1'b1, pk(1'b0, 3'(k % 8), 1'b0));
      drive_cycle(1'b0, 8'hFF, 1'b0, pk(1'b0, 3'(k % 8), 1'b0));
    end
    drive_cycle(1'b0, 8'h00, 1'b0, pk(1'b0, 3'd0, 1'b0));

    phase = "timeout";
    drive_cycle(1'b0, 8'h20, 1'b0, pk(1'b1, 3'd5, 1'b0));
    for (int i = 0; i < 15; i++)
      drive_cycle(1'b0, 8'h20, 1'b0, pk(1'b1, 3'd5, 1'b0));
    drive_cycle(1'b0, 8'h20, 1'b0, pk(1'b0, 3'd5, 1'b1));
    drive_cycle(1'b0, 8'h20, 1'b0, pk(1'b0, 3'd5, 1'b0));
    drive_cycle(1'b0, 8'h20, 1'b0, pk(1'b1, 3'd5, 1'b0));

    phase = "coincide";
    for (int i = 0; i < 15; i++)
      drive_cycle(1'b0, 8'h20, 1'b0, pk(1'b1, 3'd5, 1'b0));
    drive_cycle(1'b0, 8'h20, 1'b1, pk(1'b0, 3'd5, 1'b0));
    drive_cycle(1'b0, 8'h00, 1'b0, pk(1'b0, 3'd5, 1'b0));

    phase = "req_drop";
    drive_cycle(1'b0, 8'h02, 1'b0, pk(1'b1, 3'd1, 1'b0));
    drive_cycle(1'b0, 8'h02, 1'b0, pk(1'b1, 3'd1, 1'b0));
    drive_cycle(1'b0, 8'h00, 1'b0, pk(1'b0, 3'd1, 1'b0));
    drive_cycle(1'b0, 8'h00, 1'b0, pk(1'b0, 3'd1, 1'b0));

    phase = "holder_last";
    drive_cycle(1'b0, 8'h0A, 1'b0, pk(1'b1, 3'd3, 1'b0));
    drive_cycle(1'b0, 8'h0A, 1'b1, pk(1'b0, 3'd3, 1'b0));
    drive_cycle(1'b0, 8'h0A, 1'b0, pk(1'b0, 3'd3, 1'b0));
    drive_cycle(1'b0, 8'h0A, 1'b0, pk(1'b1, 3'd1, 1'b0));
    drive_cycle(1'b0, 8'h0A, 1'b1, pk(1'b0, 3'd1, 1'b0));
    drive_cycle(1'b0, 8'h00, 1'b0, pk(1'b0, 3'd1, 1'b0));
    drive_cycle(1'b0, 8'h00, 1'b1, pk(1'b0, 3'd1, 1'b0));

    phase = "reset_busy";
    drive_cycle(1'b0, 8'h08, 1'b0, pk(1'b1, 3'd3, 1'b0));
    drive_cycle(1'b0, 8'h08, 1'b0, pk(1'b1, 3'd3, 1'b0));
    drive_cycle(1'b1, 8'h08, 1'b0, pk(1'b0, 3'd7, 1'b0));
    drive_cycle(1'b0, 8'h09, 1'b0, pk(1'b1, 3'd0, 1'b0));
    drive_cycle(1'b0, 8'h09, 1'b1, pk(1'b0, 3'd0, 1'b0));
    drive_cycle(1'b0, 8'h00, 1'b0, pk(1'b0, 3'd0, 1'b0));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: %0d expectations left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
